// File: rtl/pipeio_in_cond_pkg.sv
// Shared constants for the input-conditioning stage: debounce FSM state
// encoding, change-counter width and a saturating add helper.
// Latency: n/a (package). Backpressure: n/a.
package pipeio_in_cond_pkg;

  // Debounce FSM states
  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_VERIFY = 1'b1;

  // Accepted-change counter
  localparam int                    CHG_CNT_W   = 8;
  localparam logic [CHG_CNT_W-1:0]  CHG_CNT_MAX = '1;

  // Add 0..3 to the counter, clamping at all-ones instead of wrapping.
  function automatic logic [CHG_CNT_W-1:0] sat_add(
    input logic [CHG_CNT_W-1:0] a,
    input logic [1:0]           b
  );
    logic [CHG_CNT_W:0] sum;
    sum = {1'b0, a} + {{(CHG_CNT_W-1){1'b0}}, b};
    return sum[CHG_CNT_W] ? CHG_CNT_MAX : sum[CHG_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pipeio_debounce.sv
// Purpose: synchronise and debounce one PW-bit switch port.
// Latency: 2 sync cycles + DEB_CYCLES from a clean raw edge to in_port.
// Backpressure: none; raw inputs are sampled every cycle.
// Ports: clock/resetn (async active-low), sw (raw async input),
//        in_port (debounced registered value), accept (1-cycle strobe,
//        high in the cycle whose rising edge loads in_port).
module pipeio_debounce
  import pipeio_in_cond_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          PW         = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [PW-1:0] sw,
  output logic [PW-1:0] in_port,
  output logic          accept
);

  localparam logic [15:0] CNT_LAST = DEB_CYCLES - 16'd1;

  logic [PW-1:0] sync0;
  logic [PW-1:0] sync1;
  logic [PW-1:0] cand;
  logic [0:0]    state;
  logic [15:0]   cnt;

  // In VERIFY cand always differs from in_port, so this cannot collide with
  // the "glitch returned" branch below.
  assign accept = (state == ST_VERIFY) && (sync1 == cand) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync0   <= '0;
      sync1   <= '0;
      cand    <= '0;
      in_port <= '0;
      cnt     <= '0;
      state   <= ST_STABLE;
    end else begin
      sync0 <= sw;
      sync1 <= sync0;
      case (state)
        ST_STABLE: begin
          if (sync1 != in_port) begin
            cand  <= sync1;
            cnt   <= 16'd1;
            state <= ST_VERIFY;
          end else begin
            cnt <= '0;
          end
        end
        ST_VERIFY: begin
          if (sync1 == in_port) begin
            // Input bounced back: drop the candidate, keep the output.
            cnt   <= '0;
            state <= ST_STABLE;
          end else if (sync1 != cand) begin
            // Moved to yet another value: restart qualification on it.
            cand <= sync1;
            cnt  <= 16'd1;
          end else if (cnt == CNT_LAST) begin
            in_port <= cand;
            cnt     <= '0;
            state   <= ST_STABLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeio_in_cond.sv
// Purpose: condition two switch ports for the CPU and flag accepted changes.
// Latency: 2 sync cycles + DEB_CYCLES to in_port*; changed/chg_cnt update
//          on the same edge as in_port*. Backpressure: none.
// Ports: clock, resetn (async active-low), sw0/sw1 (raw), ack (clears
//        changed), in_port0/in_port1 (debounced), changed (sticky),
//        chg_cnt (saturating count of accepted changes).
module pipeio_in_cond
  import pipeio_in_cond_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          PW         = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [PW-1:0]        sw0,
  input  logic [PW-1:0]        sw1,
  input  logic                 ack,
  output logic [PW-1:0]        in_port0,
  output logic [PW-1:0]        in_port1,
  output logic                 changed,
  output logic [CHG_CNT_W-1:0] chg_cnt
);

  logic accept0;
  logic accept1;

  pipeio_debounce #(.DEB_CYCLES(DEB_CYCLES), .PW(PW)) u_deb0 (
    .clock   (clock),
    .resetn  (resetn),
    .sw      (sw0),
    .in_port (in_port0),
    .accept  (accept0)
  );

  pipeio_debounce #(.DEB_CYCLES(DEB_CYCLES), .PW(PW)) u_deb1 (
    .clock   (clock),
    .resetn  (resetn),
    .sw      (sw1),
    .in_port (in_port1),
    .accept  (accept1)
  );

  logic [1:0] n_accept;
  assign n_accept = {1'b0, accept0} + {1'b0, accept1};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      changed <= 1'b0;
      chg_cnt <= '0;
    end else begin
      // A new accept beats a simultaneous ack so no change is ever lost.
      if (accept0 || accept1) begin
        changed <= 1'b1;
      end else if (ack) begin
        changed <= 1'b0;
      end
      chg_cnt <= sat_add(chg_cnt, n_accept);
    end
  end

endmodule

// File: tb/tb_pipeio_in_cond.sv
module tb_pipeio_in_cond;

  localparam int          PW  = 4;
  localparam int          DEB = 4;

  logic          clock;
  logic          resetn;
  logic [PW-1:0] sw0;
  logic [PW-1:0] sw1;
  logic          ack;
  logic [PW-1:0] in_port0;
  logic [PW-1:0] in_port1;
  logic          changed;
  logic [7:0]    chg_cnt;

  pipeio_in_cond #(.DEB_CYCLES(16'd4), .PW(PW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .sw0      (sw0),
    .sw1      (sw1),
    .ack      (ack),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .changed  (changed),
    .chg_cnt  (chg_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit saw_one  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an input value is accepted once the synchronised input
  // has shown the same value, different from the current output, on DEB
  // consecutive clock edges. Synchroniser modelled as a 2-edge delay line.
  logic [PW-1:0] m_dly0 [2];
  logic [PW-1:0] m_dly1 [2];
  logic [PW-1:0] m_port [2];
  logic [PW-1:0] m_run_val [2];
  int            m_run_len [2];
  bit            m_changed;
  int            m_cnt;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_dly0[p] = '0; m_dly1[p] = '0; m_port[p] = '0;
      m_run_val[p] = '0; m_run_len[p] = 0;
    end
    m_changed = 0;
    m_cnt     = 0;
  endtask

  task automatic model_step();
    int            acc;
    logic [PW-1:0] s;
    acc = 0;
    for (int p = 0; p < 2; p++) begin
      s         = m_dly1[p];
      m_dly1[p] = m_dly0[p];
      m_dly0[p] = (p == 0) ? sw0 : sw1;
      if (s == m_port[p]) m_run_len[p] = 0;
      else if (m_run_len[p] > 0 && s == m_run_val[p]) m_run_len[p]++;
      else begin
        m_run_val[p] = s;
        m_run_len[p] = 1;
      end
      if (m_run_len[p] == DEB) begin
        m_port[p]    = s;
        m_run_len[p] = 0;
        acc++;
      end
    end
    if (acc > 0) m_changed = 1;
    else if (ack) m_changed = 0;
    m_cnt = (m_cnt + acc > 255) ? 255 : m_cnt + acc;
  endtask

  task automatic compare_all();
    check_val("in_port0", 32'(in_port0), 32'(m_port[0]));
    check_val("in_port1", 32'(in_port1), 32'(m_port[1]));
    check_val("changed",  32'(changed),  32'(m_changed));
    check_val("chg_cnt",  32'(chg_cnt),  32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clock);
    if (resetn) model_step();
    #1;
    if (in_port0 === 4'h1) saw_one = 1;
    compare_all();
  endtask

  initial begin
    logic [PW-1:0] v;
    sw0 = '0; sw1 = '0; ack = 1'b0; resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_in_port0", 32'(in_port0), 32'h0);
    check_val("rst_in_port1", 32'(in_port1), 32'h0);
    check_val("rst_changed",  32'(changed),  32'h0);
    check_val("rst_chg_cnt",  32'(chg_cnt),  32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // Clean change on port 0: output moves on exactly the 6th edge.
    sw0 = 4'h5;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check_val("p0_not_yet", 32'(in_port0), 32'h0);
    end
    check_val("p0_lat6",   32'(in_port0), 32'h5);
    check_val("p0_chg",    32'(changed),  32'h1);
    check_val("p0_cnt",    32'(chg_cnt),  32'h1);
    repeat (2) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check_val("ack_clear", 32'(changed), 32'h0);

    // Short glitch on port 1 is rejected.
    sw1 = 4'hA; tick(); tick(); sw1 = 4'h0;
    repeat (8) tick();
    check_val("glitch_p1",  32'(in_port1), 32'h0);
    check_val("glitch_chg", 32'(changed),  32'h0);
    check_val("glitch_cnt", 32'(chg_cnt),  32'h1);

    // Candidate replaced mid-qualification.
    saw_one = 0;
    sw0 = 4'h1; tick(); tick(); sw0 = 4'h3;
    repeat (10) tick();
    check_val("step_no1",  32'(saw_one),  32'h0);
    check_val("step_p0",   32'(in_port0), 32'h3);
    check_val("step_cnt",  32'(chg_cnt),  32'h2);

    // Simultaneous accept on both ports with ack on the accept cycle.
    sw0 = 4'h6; sw1 = 4'h9;
    repeat (5) tick();
    check_val("dual_p0_early", 32'(in_port0), 32'h3);
    ack = 1'b1; tick(); ack = 1'b0;
    check_val("dual_p0",  32'(in_port0), 32'h6);
    check_val("dual_p1",  32'(in_port1), 32'h9);
    check_val("dual_chg", 32'(changed),  32'h1);
    check_val("dual_cnt", 32'(chg_cnt),  32'h4);

    // Random switch activity with random acks.
    for (int it = 0; it < 60; it++) begin
      sw0 = 4'($urandom);
      sw1 = 4'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
        ack = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    ack = 1'b0;
    repeat (8) tick();

    // 300 accepted changes drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      sw0 = (m_port[0] == 4'h5) ? 4'hA : 4'h5;
      repeat (7) tick();
    end
    check_val("sat_cnt", 32'(chg_cnt), 32'hFF);

    // Asynchronous reset in the middle of qualification.
    sw1 = 4'h0;
    repeat (8) tick();
    v = (m_port[0] == 4'hC) ? 4'h3 : 4'hC;
    sw0 = v;
    repeat (4) tick();
    #2 resetn = 1'b0;
    #1;
    check_val("arst_p0",  32'(in_port0), 32'h0);
    check_val("arst_p1",  32'(in_port1), 32'h0);
    check_val("arst_chg", 32'(changed),  32'h0);
    check_val("arst_cnt", 32'(chg_cnt),  32'h0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check_val("requal_early", 32'(in_port0), 32'h0);
    end
    check_val("requal_p0",  32'(in_port0), 32'(v));
    check_val("requal_cnt", 32'(chg_cnt),  32'h1);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
